// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined parallel-prefix adder.
package adder_pkg;

  // Generate/propagate pair carried through every prefix level.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of Ladner-Fischer prefix levels for a given operand width.
  function automatic int num_levels(input int width);
    return clog2(width);
  endfunction

  // Whether a pipeline register follows prefix level `level`. The input
  // register always exists, so pipe_stages-1 further registers are spread
  // evenly over the levels; the last level gets one first when few are asked for.
  function automatic logic reg_after(input int level, input int levels, input int pipe_stages);
    int r;
    r = pipe_stages - 1;
    return (((level + 1) * r) / levels) != ((level * r) / levels);
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Ladner-Fischer (minimum-depth) prefix level.
// Bit i with bit LEVEL of its index set merges with the top bit of the
// preceding 2^LEVEL block; all other bits pass through unchanged.
module prefix_level
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_in,
  output gp_t [WIDTH-1:0] gp_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> LEVEL) & 1) == 1) begin : g_cell
      localparam int J = ((i >> LEVEL) << LEVEL) - 1;
      assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[J].g);
      assign gp_out[i].p = gp_in[i].p & gp_in[J].p;
    end else begin : g_pass
      assign gp_out[i] = gp_in[i];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready flow control.
// Register 1 captures the effective operands; the remaining PIPE_STAGES-1
// registers sit after prefix levels as chosen by adder_pkg::reg_after.
// A single global enable stalls every stage when the output is held.
module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = num_levels(WIDTH);

  // Everything a beat needs downstream: running (g,p) prefixes, the raw
  // per-bit propagate for the final XOR, and the effective carry-in.
  typedef struct packed {
    logic              vld;
    gp_t [WIDTH-1:0]   gp;
    logic [WIDTH-1:0]  p;
    logic              cx;
  } beat_t;

  logic             en;
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] a_d, a_q, bx_d, bx_q;
  logic             cx_d, cx_q;
  beat_t            base;
  beat_t            fin;
  logic [WIDTH-1:0] carry;
  logic             unused_gp_p;

  assign en       = !fin.vld | out_ready;
  assign in_ready = en;

  // Input register: capture effective operands (B and cin inverted for subtract).
  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    bx_d  = bx_q;
    cx_d  = cx_q;
    if (en) begin
      vld_d = in_valid;
      a_d   = a;
      bx_d  = b ^ {WIDTH{sub}};
      cx_d  = cin ^ sub;
    end
  end

  // Input register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      bx_q  <= '0;
      cx_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      bx_q  <= bx_d;
      cx_q  <= cx_d;
    end
  end

  // Bit-level generate/propagate; carry-in is folded into bit 0's generate.
  always_comb begin
    base     = '0;
    base.vld = vld_q;
    base.p   = a_q ^ bx_q;
    base.cx  = cx_q;
    for (int i = 0; i < WIDTH; i++) begin
      base.gp[i].g = a_q[i] & bx_q[i];
      base.gp[i].p = a_q[i] ^ bx_q[i];
    end
    base.gp[0].g = (a_q[0] & bx_q[0]) | ((a_q[0] ^ bx_q[0]) & cx_q);
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    beat_t           stg_in;
    beat_t           lvl_out;
    beat_t           stg_out;
    gp_t [WIDTH-1:0] gp_res;

    if (l == 0) begin : g_first
      assign stg_in = base;
    end else begin : g_next
      assign stg_in = g_lvl[l-1].stg_out;
    end

    prefix_level #(
      .WIDTH (WIDTH),
      .LEVEL (l)
    ) u_level (
      .gp_in  (stg_in.gp),
      .gp_out (gp_res)
    );

    // Replace the prefixes with this level's result; other fields ride along.
    always_comb begin
      lvl_out    = stg_in;
      lvl_out.gp = gp_res;
    end

    if (reg_after(l, LEVELS, PIPE_STAGES)) begin : g_reg
      beat_t stg_d, stg_q;

      // Advance only when the whole pipe is enabled.
      always_comb begin
        stg_d = stg_q;
        if (en) stg_d = lvl_out;
      end

      // Stage register after this level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
      end

      assign stg_out = stg_q;
    end else begin : g_comb
      assign stg_out = lvl_out;
    end
  end

  assign fin = g_lvl[LEVELS-1].stg_out;

  // Final XOR: carry into bit i is the group generate of bits i-1..0 (plus cin).
  always_comb begin
    carry    = '0;
    carry[0] = fin.cx;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = fin.gp[i-1].g;
    end
  end

  assign out_valid = fin.vld;
  assign sum       = fin.p ^ carry;
  assign cout      = fin.gp[WIDTH-1].g;
  assign ovf       = carry[WIDTH-1] ^ fin.gp[WIDTH-1].g;

  // Group propagates of the last level have no consumer.
  always_comb begin
    unused_gp_p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      unused_gp_p = unused_gp_p ^ fin.gp[i].p;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder (WIDTH=8, PIPE_STAGES=2).
module tb_pipelined_prefix_adder;

  localparam int W = 8;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic [W+1:0] exp_q[$];

  bit sink_rand  = 1'b0;
  bit sink_force = 1'b1;

  logic         held_valid = 1'b0;
  logic [W+1:0] held_val   = '0;

  always #5 clk = ~clk;

  pipelined_prefix_adder #(
    .WIDTH       (W),
    .PIPE_STAGES (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: plain integer arithmetic, returns {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                         input logic tc, input logic ts);
    int ua, ub, uc, tot, sa, sb, st;
    logic so, sc;
    logic [W-1:0] s;
    ua  = int'(ta);
    ub  = ts ? ((~int'(tb_v)) & ((1 << W) - 1)) : int'(tb_v);
    uc  = (tc ^ ts) ? 1 : 0;
    tot = ua + ub + uc;
    sa  = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb  = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    st  = sa + sb + uc;
    so  = (st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1)));
    sc  = (tot >= (1 << W));
    s   = W'(tot);
    return {sc, so, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Sink: out_ready changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = sink_rand ? ($urandom_range(0, 3) != 0) : sink_force;
  end

  // Monitor: pop and compare on every consumed result; check stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) check("hold_stable", {out_valid, cout, ovf, sum}, {1'b1, held_val});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_result: got sum=0x%0h with no beat outstanding", sum);
        end else begin
          check("result", {cout, ovf, sum}, exp_q.pop_front());
        end
        pops++;
        held_valid = 1'b0;
      end else if (out_valid) begin
        held_valid = 1'b1;
        held_val   = {cout, ovf, sum};
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  // Drive one beat and wait until it is accepted; returns at 2 ns after the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, output int stalls);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    stalls = 0;
    while (!in_ready && stalls < 200) begin
      @(posedge clk); #2;
      stalls++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles", stalls);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(ta, tb_v, tc, ts));
      @(posedge clk); #2;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk); #2;
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int st, st_sum, p0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_in_ready", in_ready, 1);

    // Wrap-around and latency: visible after P register edges.
    send(8'hFF, 8'h01, 1'b0, 1'b0, st);
    in_valid = 1'b0;
    check("lat_early", out_valid, 0);
    @(posedge clk); #2;
    check("lat_arrive", out_valid, 1);
    check("wrap_value", {cout, ovf, sum}, {1'b1, 1'b0, 8'h00});
    idle(2);

    // Signed overflow and subtraction
    send(8'h7F, 8'h01, 1'b0, 1'b0, st);
    send(8'h05, 8'h07, 1'b0, 1'b1, st);
    send(8'h80, 8'h01, 1'b0, 1'b1, st);
    send(8'h10, 8'h20, 1'b1, 1'b0, st);
    drain();

    // Backpressure: 3 beats against a stalled sink
    sink_force = 1'b0;
    @(posedge clk); #2;
    send(8'h11, 8'h22, 1'b0, 1'b0, st);
    send(8'h33, 8'h44, 1'b1, 1'b0, st);
    a = 8'h55; b = 8'h66; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_valid", out_valid, 1);
    repeat (4) begin
      @(posedge clk); #2;
    end
    check("bp_still_full", in_ready, 0);
    p0 = pops;
    sink_force = 1'b1;
    send(8'h55, 8'h66, 1'b0, 1'b1, st);
    in_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("bp_release_rate", pops - p0, 3);
    drain();

    // Reset with two beats in flight
    send(8'hA5, 8'h5A, 1'b0, 1'b0, st);
    send(8'h01, 8'h02, 1'b0, 1'b0, st);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {cout, ovf, sum}, 0);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    p0 = pops;
    idle(6);
    check("midrst_no_stale", pops - p0, 0);

    // Back-to-back burst with an always-ready sink
    st_sum = 0;
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      send(pick(), pick(), 1'($urandom), 1'($urandom), st);
      st_sum += st;
    end
    idle(P + 2);
    check("burst_stalls", st_sum, 0);
    check("burst_count", pops - p0, 64);

    // Random traffic with random backpressure
    sink_rand = 1'b1;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(pick(), pick(), 1'($urandom), 1'($urandom), st);
    end
    sink_rand  = 1'b0;
    sink_force = 1'b1;
    drain();
    check("rand_count", pops - p0, 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
